// File: rtl/acc_stream_router.sv
// Routes a DMA input stream to one of N_CH accelerators and gathers that channel's results in a FIFO.
// Optional per-channel fed-word statistics are enabled by defining ACC_STREAM_ROUTER_STATS_EN.

module acc_stream_router #(
  parameter int  DATA_WIDTH = 32,
  parameter int  N_CH       = 4,
  parameter int  DEPTH      = 4,
  parameter int  LEN_W      = 16,
  localparam int SEL_W      = $clog2(N_CH)
) (
  input  logic                       wb_clk_i,
  input  logic                       wb_rst_ni,
  input  logic                       cfg_start_i,
  input  logic [SEL_W-1:0]           cfg_sel_i,
  input  logic [LEN_W-1:0]           cfg_len_i,
  input  logic [LEN_W-1:0]           cfg_res_len_i,
  output logic                       busy_o,
  output logic                       done_o,
  output logic                       err_o,
  input  logic                       in_valid_i,
  input  logic [DATA_WIDTH-1:0]      in_data_i,
  output logic                       in_ready_o,
  output logic [N_CH-1:0]            acc_valid_o,
  output logic [DATA_WIDTH-1:0]      acc_data_o,
  input  logic [N_CH-1:0]            acc_ready_i,
  input  logic [N_CH-1:0]            acc_res_valid_i,
  input  logic [N_CH*DATA_WIDTH-1:0] acc_res_data_i,
  output logic                       out_valid_o,
  output logic [DATA_WIDTH-1:0]      out_data_o,
`ifdef ACC_STREAM_ROUTER_STATS_EN
  output logic [N_CH*32-1:0]         stat_words_o,
`endif
  input  logic                       out_ready_i
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int NSEL  = 1 << SEL_W;
  // One bit per encodable select value; set where the value names a real channel.
  localparam logic [NSEL-1:0] SEL_OK = NSEL'((1 << N_CH) - 1);

  typedef enum logic [1:0] {IDLE, FEED, DRAIN, DONE} state_e;

  state_e                state_q, state_d;
  logic [SEL_W-1:0]      sel_q;
  logic [LEN_W-1:0]      len_q, res_len_q, feed_cnt_q, res_cnt_q;
  logic                  err_q;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W:0]        wr_ptr_q, rd_ptr_q, fill, fill_nxt;

  logic active, start_ok, start_bad, feed_xfer, last_feed;
  logic fifo_empty, fifo_full, pop, res_req, push, drop, drain_done;

  assign active     = (state_q == FEED) || (state_q == DRAIN);
  assign start_ok   = (state_q == IDLE) && cfg_start_i && SEL_OK[cfg_sel_i];
  assign start_bad  = (state_q == IDLE) && cfg_start_i && !SEL_OK[cfg_sel_i];
  assign feed_xfer  = (state_q == FEED) && in_valid_i && acc_ready_i[sel_q];
  assign last_feed  = feed_xfer && (feed_cnt_q == len_q - LEN_W'(1));

  assign fill       = wr_ptr_q - rd_ptr_q;
  assign fifo_empty = (fill == '0);
  assign fifo_full  = (fill == (PTR_W+1)'(DEPTH));
  assign pop        = !fifo_empty && out_ready_i;
  assign res_req    = active && acc_res_valid_i[sel_q] && (res_cnt_q < res_len_q);
  // A full FIFO still accepts when the head leaves in the same cycle.
  assign push       = res_req && (!fifo_full || pop);
  assign drop       = res_req && fifo_full && !pop;
  assign fill_nxt   = fill + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
  // Judge completion on post-update values so DONE follows the final pop directly.
  assign drain_done = ((res_cnt_q + LEN_W'(res_req)) == res_len_q) && (fill_nxt == '0);

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) state_q <= IDLE;
    else            state_q <= state_d;
  end

  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    state_d     = state_q;
    in_ready_o  = 1'b0;
    acc_valid_o = '0;
    acc_data_o  = '0;
    case (state_q)
      IDLE: begin
        if (start_ok) begin
          if (cfg_len_i != '0)          state_d = FEED;
          else if (cfg_res_len_i != '0) state_d = DRAIN;
          else                          state_d = DONE;
        end
      end
      FEED: begin
        acc_data_o         = in_data_i;
        acc_valid_o[sel_q] = in_valid_i;
        in_ready_o         = acc_ready_i[sel_q];
        if (last_feed) state_d = DRAIN;
      end
      DRAIN:   if (drain_done) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy_o      = active;
  assign done_o      = (state_q == DONE);
  assign err_o       = err_q;
  assign out_valid_o = !fifo_empty;
  assign out_data_o  = fifo_empty ? '0 : mem[rd_ptr_q[PTR_W-1:0]];

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      sel_q      <= '0;
      len_q      <= '0;
      res_len_q  <= '0;
      feed_cnt_q <= '0;
      res_cnt_q  <= '0;
      err_q      <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      if (start_ok) begin
        sel_q      <= cfg_sel_i;
        len_q      <= cfg_len_i;
        res_len_q  <= cfg_res_len_i;
        feed_cnt_q <= '0;
        res_cnt_q  <= '0;
      end else begin
        if (feed_xfer) feed_cnt_q <= feed_cnt_q + LEN_W'(1);
        if (res_req)   res_cnt_q  <= res_cnt_q + LEN_W'(1);
      end
      if (start_ok)                err_q <= 1'b0;
      else if (start_bad || drop)  err_q <= 1'b1;
      if (push) wr_ptr_q <= wr_ptr_q + (PTR_W+1)'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + (PTR_W+1)'(1);
    end
  end

  // NOTE: storage is not reset; emptiness comes from the pointers and the head is masked when empty.
  always_ff @(posedge wb_clk_i) begin
    if (push) mem[wr_ptr_q[PTR_W-1:0]] <= acc_res_data_i[sel_q*DATA_WIDTH +: DATA_WIDTH];
  end

`ifdef ACC_STREAM_ROUTER_STATS_EN
  logic [31:0] stat_q [N_CH];

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      for (int k = 0; k < N_CH; k++) stat_q[k] <= '0;
    end else if (feed_xfer && (stat_q[sel_q] != '1)) begin
      stat_q[sel_q] <= stat_q[sel_q] + 32'd1;
    end
  end

  for (genvar k = 0; k < N_CH; k++) begin : g_stat
    assign stat_words_o[k*32 +: 32] = stat_q[k];
  end
`endif

endmodule

// File: tb/tb_acc_stream_router.sv
// Self-checking bench for acc_stream_router: directed scenarios plus randomized jobs,
// all compared cycle by cycle against a queue-based job model.

module tb_acc_stream_router;

  localparam int DW    = 32;
  localparam int NCH   = 5;
  localparam int DEPTH = 4;
  localparam int LW    = 16;
  localparam int SW    = 3;
  localparam int VW    = 10 + 2*DW;

  logic              wb_clk_i = 1'b0;
  logic              wb_rst_ni;
  logic              cfg_start;
  logic [SW-1:0]     cfg_sel;
  logic [LW-1:0]     cfg_len, cfg_res_len;
  logic              busy, done, err;
  logic              in_valid, in_ready;
  logic [DW-1:0]     in_data;
  logic [NCH-1:0]    acc_valid, acc_ready, acc_res_valid;
  logic [DW-1:0]     acc_data;
  logic [NCH*DW-1:0] acc_res_data;
  logic              out_valid, out_ready;
  logic [DW-1:0]     out_data;
`ifdef ACC_STREAM_ROUTER_STATS_EN
  logic [NCH*32-1:0] stat_words;
`endif

  acc_stream_router #(.DATA_WIDTH(DW), .N_CH(NCH), .DEPTH(DEPTH), .LEN_W(LW)) dut (
    .wb_clk_i        (wb_clk_i),
    .wb_rst_ni       (wb_rst_ni),
    .cfg_start_i     (cfg_start),
    .cfg_sel_i       (cfg_sel),
    .cfg_len_i       (cfg_len),
    .cfg_res_len_i   (cfg_res_len),
    .busy_o          (busy),
    .done_o          (done),
    .err_o           (err),
    .in_valid_i      (in_valid),
    .in_data_i       (in_data),
    .in_ready_o      (in_ready),
    .acc_valid_o     (acc_valid),
    .acc_data_o      (acc_data),
    .acc_ready_i     (acc_ready),
    .acc_res_valid_i (acc_res_valid),
    .acc_res_data_i  (acc_res_data),
    .out_valid_o     (out_valid),
    .out_data_o      (out_data),
`ifdef ACC_STREAM_ROUTER_STATS_EN
    .stat_words_o    (stat_words),
`endif
    .out_ready_i     (out_ready)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  int vectors    = 0;
  int miscompares = 0;

  // Job-level model: where the job is, what it was asked to do, and the result queue.
  typedef enum int {M_IDLE, M_FEED, M_DRAIN, M_DONE} mphase_e;
  mphase_e     m_ph;
  int          m_sel, m_len, m_rlen, m_fed, m_res;
  bit          m_err;
  logic [DW-1:0] m_q[$];

  task automatic model_reset();
    m_ph = M_IDLE; m_sel = 0; m_len = 0; m_rlen = 0; m_fed = 0; m_res = 0; m_err = 0;
    m_q.delete();
  endtask

  task automatic model_step();
    bit pop, do_push;
    if (!wb_rst_ni) begin model_reset(); return; end
    pop = (m_q.size() != 0) && out_ready;
    do_push = 0;
    if ((m_ph == M_FEED || m_ph == M_DRAIN) && acc_res_valid[m_sel] && m_res < m_rlen) begin
      m_res++;
      if (m_q.size() < DEPTH || pop) do_push = 1;
      else m_err = 1;
    end
    if (pop) void'(m_q.pop_front());
    if (do_push) m_q.push_back(acc_res_data[m_sel*DW +: DW]);
    case (m_ph)
      M_IDLE: if (cfg_start) begin
        if (int'(cfg_sel) >= NCH) m_err = 1;
        else begin
          m_err = 0; m_sel = cfg_sel; m_len = cfg_len; m_rlen = cfg_res_len; m_fed = 0; m_res = 0;
          if (m_len != 0)       m_ph = M_FEED;
          else if (m_rlen != 0) m_ph = M_DRAIN;
          else                  m_ph = M_DONE;
        end
      end
      M_FEED: if (in_valid && acc_ready[m_sel]) begin
        m_fed++;
        if (m_fed == m_len) m_ph = M_DRAIN;
      end
      M_DRAIN: if (m_res == m_rlen && m_q.size() == 0) m_ph = M_DONE;
      M_DONE:  m_ph = M_IDLE;
      default: m_ph = M_IDLE;
    endcase
  endtask

  function automatic logic [VW-1:0] exp_vec();
    logic           feed = (m_ph == M_FEED);
    logic [NCH-1:0] av   = '0;
    logic [DW-1:0]  head = (m_q.size() != 0) ? m_q[0] : '0;
    if (feed && in_valid) av[m_sel] = 1'b1;
    return {logic'(m_ph == M_FEED || m_ph == M_DRAIN), logic'(m_ph == M_DONE), logic'(m_err),
            feed ? acc_ready[m_sel] : 1'b0, av, logic'(m_q.size() != 0), head,
            feed ? in_data : '0};
  endfunction

  // acc_data and out_data only carry meaning while feeding / while the queue holds data.
  function automatic logic [VW-1:0] dut_vec();
    return {busy, done, err, in_ready, acc_valid, out_valid,
            (m_q.size() != 0) ? out_data : '0, (m_ph == M_FEED) ? acc_data : '0};
  endfunction

  task automatic advance();
    @(posedge wb_clk_i);
    model_step();
    @(negedge wb_clk_i);
  endtask

  task automatic run_job(input string tag, input int sel, input int len, input int rlen,
                         input int p_valid, input int p_ready, input int p_res, input int p_out);
    int n = 0;
    cfg_start = 1'b1; cfg_sel = sel[SW-1:0]; cfg_len = len[LW-1:0]; cfg_res_len = rlen[LW-1:0];
    do begin
      if (n > 0) begin
        cfg_start   = ($urandom_range(99) < 5);
        cfg_sel     = SW'($urandom);
        cfg_len     = LW'($urandom_range(20));
        cfg_res_len = LW'($urandom_range(20));
      end
      in_valid = ($urandom_range(99) < p_valid);
      in_data  = $urandom;
      for (int k = 0; k < NCH; k++) begin
        acc_ready[k]             = ($urandom_range(99) < p_ready);
        acc_res_valid[k]         = ($urandom_range(99) < p_res);
        acc_res_data[k*DW +: DW] = $urandom;
      end
      out_ready = ($urandom_range(99) < p_out);
      #1;
      vectors++;
      if (dut_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL %s cycle %0d: dut=%h expected=%h", tag, n, dut_vec(), exp_vec());
      end
      advance();
      n++;
    end while (m_ph != M_IDLE && n < 600);
    cfg_start = 1'b0;
    if (m_ph != M_IDLE) begin
      vectors++; miscompares++;
      $display("FAIL %s timeout: job still active after %0d cycles, expected completion", tag, n);
    end
  endtask

  task automatic test_reset();
    wb_rst_ni = 1'b0; model_reset();
    in_valid = 1; acc_ready = '1; acc_res_valid = '1; acc_res_data = '1; out_ready = 1;
    cfg_start = 1; cfg_sel = 1; cfg_len = 3; cfg_res_len = 3; in_data = 32'hA5A5_A5A5;
    @(negedge wb_clk_i);
    for (int c = 0; c < 3; c++) begin
      #1;
      vectors++;
      if ({busy, done, err, in_ready, acc_valid, out_valid} !== '0 || dut_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL reset_outputs: dut=%h expected all zero", dut_vec());
      end
      advance();
    end
    wb_rst_ni = 1'b1;
    cfg_start = 0; in_valid = 0; acc_res_valid = '0; out_ready = 0;
    #1;
    vectors++;
    if (dut_vec() !== exp_vec()) begin
      miscompares++;
      $display("FAIL reset_release: dut=%h expected=%h", dut_vec(), exp_vec());
    end
    advance();
  endtask

`ifdef ACC_STREAM_ROUTER_STATS_EN
  task automatic test_stats();
    run_job("stats_ch0", 0, 3, 0, 100, 100, 0, 100);
    run_job("stats_ch3", 3, 2, 0, 100, 100, 0, 100);
    for (int k = 0; k < NCH; k++) begin
      logic [31:0] want = (k == 0) ? 32'd3 : (k == 3) ? 32'd2 : 32'd0;
      vectors++;
      if (stat_words[k*32 +: 32] !== want) begin
        miscompares++;
        $display("FAIL stats ch%0d: dut=%0d expected=%0d", k, stat_words[k*32 +: 32], want);
      end
    end
  endtask
`endif

  task automatic test_basic();
    cfg_sel = 2; cfg_len = 4; cfg_res_len = 1; acc_ready = '1; in_valid = 1; out_ready = 1;
    for (int c = 0; c < 10; c++) begin
      cfg_start     = (c == 0);
      in_data       = $urandom;
      acc_res_valid = (c == 6) ? 5'b00101 : 5'b00000;
      acc_res_data  = '0;
      acc_res_data[2*DW +: DW] = 32'h0000_CAFE;
      acc_res_data[0 +: DW]    = 32'h1234_5678;
      #1;
      vectors++;
      if (dut_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL basic cycle %0d: dut=%h expected=%h", c, dut_vec(), exp_vec());
      end
      if (c >= 1 && c <= 4) begin
        vectors++;
        if (acc_valid !== 5'b00100 || in_ready !== 1'b1) begin
          miscompares++;
          $display("FAIL basic_route cycle %0d: acc_valid=%b in_ready=%b expected 00100/1", c, acc_valid, in_ready);
        end
      end
      if (c == 7) begin
        vectors++;
        if (out_valid !== 1'b1 || out_data !== 32'h0000_CAFE) begin
          miscompares++;
          $display("FAIL basic_result: valid=%b data=%h expected 1/0000cafe", out_valid, out_data);
        end
      end
      if (c == 8) begin
        vectors++;
        if (done !== 1'b1) begin
          miscompares++;
          $display("FAIL basic_done: done=%b expected 1", done);
        end
      end
      advance();
    end
    in_valid = 0; acc_res_valid = '0;
  endtask

  task automatic test_backpressure();
    int xfers = 0;
    cfg_sel = 1; cfg_len = 6; cfg_res_len = 0; in_valid = 1; out_ready = 1; acc_res_valid = '0;
    for (int c = 0; c < 14; c++) begin
      cfg_start = (c == 0);
      acc_ready = (c >= 2 && c <= 4) ? 5'b11101 : 5'b11111;
      in_data   = $urandom;
      #1;
      vectors++;
      if (dut_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL backpressure cycle %0d: dut=%h expected=%h", c, dut_vec(), exp_vec());
      end
      if (c >= 2 && c <= 4) begin
        vectors++;
        if (in_ready !== 1'b0 || acc_valid !== 5'b00010) begin
          miscompares++;
          $display("FAIL backpressure_stall cycle %0d: in_ready=%b acc_valid=%b expected 0/00010", c, in_ready, acc_valid);
        end
      end
      if (in_valid && in_ready) xfers++;
      advance();
    end
    in_valid = 0;
    vectors++;
    if (xfers != 6) begin
      miscompares++;
      $display("FAIL backpressure_count: transfers=%0d expected 6", xfers);
    end
  endtask

  task automatic test_overflow();
    logic [DW-1:0] d[5];
    foreach (d[i]) d[i] = $urandom;
    cfg_sel = 0; cfg_len = 0; cfg_res_len = 5; in_valid = 0; acc_ready = '1;
    for (int c = 0; c < 12; c++) begin
      cfg_start = (c == 0);
      acc_res_valid = '0; acc_res_data = '0;
      if (c >= 1 && c <= 5) begin
        acc_res_valid = 5'b00001;
        acc_res_data[0 +: DW] = d[c-1];
      end
      out_ready = (c >= 6);
      #1;
      vectors++;
      if (dut_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL overflow cycle %0d: dut=%h expected=%h", c, dut_vec(), exp_vec());
      end
      if (c == 6) begin
        vectors++;
        if (err !== 1'b1 || out_valid !== 1'b1) begin
          miscompares++;
          $display("FAIL overflow_err: err=%b out_valid=%b expected 1/1", err, out_valid);
        end
      end
      if (c >= 6 && c <= 9) begin
        vectors++;
        if (out_data !== d[c-6]) begin
          miscompares++;
          $display("FAIL overflow_data %0d: dut=%h expected=%h", c - 6, out_data, d[c-6]);
        end
      end
      if (c == 10) begin
        vectors++;
        if (done !== 1'b1 || err !== 1'b1) begin
          miscompares++;
          $display("FAIL overflow_done: done=%b err=%b expected 1/1", done, err);
        end
      end
      advance();
    end
    acc_res_valid = '0;
    cfg_start = 1; cfg_sel = 3; cfg_len = 0; cfg_res_len = 0;
    advance();
    cfg_start = 0;
    #1;
    vectors++;
    if (err !== 1'b0 || done !== 1'b1 || dut_vec() !== exp_vec()) begin
      miscompares++;
      $display("FAIL overflow_clear: err=%b done=%b expected 0/1", err, done);
    end
    advance();
  endtask

  task automatic test_zero_len();
    int bad_sel[2] = '{5, 7};
    cfg_sel = 4; cfg_len = 0; cfg_res_len = 0; in_valid = 1; acc_ready = '1; acc_res_valid = '0;
    for (int c = 0; c < 4; c++) begin
      cfg_start = (c == 0);
      #1;
      vectors++;
      if (busy !== 1'b0 || done !== (c == 1) || dut_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL zero_len cycle %0d: busy=%b done=%b expected 0/%0d", c, busy, done, c == 1);
      end
      advance();
    end
    foreach (bad_sel[i]) begin
      cfg_sel = SW'(bad_sel[i]); cfg_len = 3; cfg_res_len = 1;
      for (int c = 0; c < 3; c++) begin
        cfg_start = (c == 0);
        #1;
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0 || (c >= 1 && err !== 1'b1) || dut_vec() !== exp_vec()) begin
          miscompares++;
          $display("FAIL bad_sel %0d cycle %0d: busy=%b done=%b err=%b expected 0/0/1", bad_sel[i], c, busy, done, err);
        end
        advance();
      end
    end
    in_valid = 0;
  endtask

  task automatic test_reset_mid();
    cfg_sel = 3; cfg_len = 8; cfg_res_len = 2; in_valid = 1; acc_ready = '1; out_ready = 0;
    for (int c = 0; c < 5; c++) begin
      cfg_start     = (c == 0);
      in_data       = $urandom;
      acc_res_valid = (c == 1) ? 5'b01000 : 5'b00000;
      acc_res_data  = {NCH{32'hBEEF_0001}};
      #1;
      vectors++;
      if (dut_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL reset_mid cycle %0d: dut=%h expected=%h", c, dut_vec(), exp_vec());
      end
      if (c < 4) advance();
    end
    #1;
    wb_rst_ni = 1'b0;
    model_reset();
    #1;
    vectors++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || acc_valid !== '0) begin
      miscompares++;
      $display("FAIL reset_mid_async: busy=%b out_valid=%b acc_valid=%b expected 0/0/0", busy, out_valid, acc_valid);
    end
    @(negedge wb_clk_i);
    for (int c = 0; c < 2; c++) begin
      #1;
      vectors++;
      if (done !== 1'b0 || dut_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL reset_mid_hold cycle %0d: done=%b dut=%h expected=%h", c, done, dut_vec(), exp_vec());
      end
      advance();
    end
    wb_rst_ni = 1'b1;
    in_valid = 0; acc_res_valid = '0;
    run_job("post_reset", 3, 5, 2, 80, 80, 60, 80);
  endtask

  task automatic test_random();
    for (int j = 0; j < 25; j++) begin
      run_job("random", $urandom_range(6), $urandom_range(12), $urandom_range(6),
              $urandom_range(100, 30), $urandom_range(100, 30),
              $urandom_range(80, 20), $urandom_range(100, 30));
    end
  endtask

  initial begin
    cfg_start = 0; cfg_sel = 0; cfg_len = 0; cfg_res_len = 0;
    in_valid = 0; in_data = 0; acc_ready = 0; acc_res_valid = 0; acc_res_data = 0; out_ready = 0;
    test_reset();
`ifdef ACC_STREAM_ROUTER_STATS_EN
    test_stats();
`endif
    test_basic();
    test_backpressure();
    test_overflow();
    test_zero_len();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
